sb_master_port: RTL and testbench
=================================

Name: sb_master_port

Overview:
- Bus-master front end of the SB bus; sits upstream of the arbiter/decoder and the SB slaves.
- Turns one local burst command into an SB transfer: bus request/grant, NONSEQ/SEQ beats, per-beat data handoff and OKAY/ERROR/SPLIT handling.
- A SPLIT-ed burst is parked, then resumed from the first unfinished beat once the slave releases this master.

Parameters:
- MASTER_ID, 1, value driven on sb_master. MASTER_ID=1 watches sb_split[0]; MASTER_ID=0 watches sb_split[1].
- TIMEOUT_CYCLES, 64, granted cycles without sb_ready before the burst aborts.

Ports:
- sb_clk  in  1  clock
- sb_resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in S_IDLE
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  start word address
- cmd_size  in  3  beat code: 010=1, 011=2, 100=3, 101=8, 110=16, 111=32; others=1
- wr_data  in  32  current write word
- wr_pop  out  1  one-cycle pulse: current write word consumed
- rd_data  out  32  read word
- rd_valid  out  1  one-cycle pulse with rd_data
- done  out  1  one-cycle pulse at burst end
- status  out  2  0=OK, 1=ERROR, 2=TIMEOUT; valid with done
- sb_busreq  out  1  bus request
- sb_grant  in  1  arbiter grant
- sb_addr  out  32  address
- sb_write  out  1  direction
- sb_trans  out  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- sb_size  out  3  latched cmd_size
- sb_burst  out  3  fixed 3'b001 (incrementing)
- sb_wdata  out  32  equals wr_data (combinational)
- sb_master  out  1  MASTER_ID
- sb_mastlock  out  1  tied 0
- sb_ready  in  1  slave ready
- sb_resp  in  2  OKAY=1, ERROR=2, SPLIT=3, 0=none
- sb_rdata  in  32  read data
- sb_split  in  2  split release bits

Behaviour:
- Reset (async, sb_resetn=0):
  - State S_IDLE.
  - All registered outputs 0; sb_trans=IDLE; rd_data=0; status=0.
  - Reset mid-burst drops busreq immediately. No done pulse is produced.
- States and transitions:
  - S_IDLE -> S_REQ on cmd_valid. Latch addr, write, size; beat_total from the size table; beat_cnt=0.
  - S_REQ: sb_busreq=1. Grant sampled high -> S_XFER.
  - S_XFER: busreq=1; drive sb_addr=base+beat_cnt.
    - First beat after any (re)grant uses NONSEQ; later beats use SEQ.
    - A beat completes on a cycle with sb_ready=1 and sb_resp=OKAY. That cycle: beat_cnt+1. Write: wr_pop=1. Read: next cycle rd_data<=sb_rdata and rd_valid=1.
    - Last beat completes -> S_DONE.
    - sb_ready=1 and resp=ERROR -> status=1, S_DONE.
    - sb_ready=1 and resp=SPLIT -> S_SPLIT. The beat is not completed and beat_cnt is held.
    - grant low with no response -> sb_trans=IDLE, stay in S_XFER. The next beat after grant returns is NONSEQ.
  - S_SPLIT: busreq=0, sb_trans=IDLE. Watched split bit=1 -> S_REQ; the resume starts at base+beat_cnt.
  - S_DONE: one cycle. done=1, busreq=0, trans=IDLE -> S_IDLE.
- Timeout:
  - The counter increments on each S_XFER cycle with grant=1 and sb_ready=0; it clears on sb_ready=1 and on state entry.
  - Reaching TIMEOUT_CYCLES -> status=2, S_DONE.
- Priority on a single cycle: ERROR > SPLIT > OKAY > timeout.
- Addresses wrap modulo 2^32.
- sb_resp=0 with sb_ready=1 is a wait cycle.
- cmd_valid outside S_IDLE is ignored.

Test Plan:
- Single write, addr 0x10, size 010, grant after 2 cycles:
  - NONSEQ at 0x10; one wr_pop; done with status 0.
  - busreq high for 3 cycles plus the beat.
- 8-beat read, addr 0x100, size 101:
  - Addresses 0x100..0x107, first NONSEQ then SEQ.
  - 8 rd_valid pulses with matching data; done.
- 8-beat write, slave SPLITs at beat 2:
  - busreq drops; 2 wr_pops so far.
  - Assert sb_split bit 0 (MASTER_ID=1) -> re-request, NONSEQ at base+2, 6 more pops, done OK.
- ERROR on beat 1 of a 3-beat read -> 1 rd_valid, done with status 1, busreq 0 the next cycle.
- Granted, ready held low 64 cycles -> done with status 2; cmd_ready back high.
- Reset asserted mid-burst at beat 4 -> all outputs 0 immediately; new command after reset starts a fresh NONSEQ.

Source files
------------

// File: rtl/sb_master_port.sv
// sb_master_port: SB bus master front end turning one local burst command into an SB transfer
// Ports:
//   sb_clk, sb_resetn                    clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/size      local burst command handshake
//   wr_data, wr_pop                      write word source, popped once per completed write beat
//   rd_data, rd_valid                    read word sink, registered one cycle after the beat
//   done, status                         end-of-burst pulse with 0=OK, 1=ERROR, 2=TIMEOUT
//   sb_busreq, sb_grant                  arbiter request/grant
//   sb_addr/write/trans/size/burst       address-phase controls
//   sb_wdata, sb_master, sb_mastlock     write data, master id, lock (always 0)
//   sb_ready, sb_resp, sb_rdata          slave response
//   sb_split                             per-master split release bits
module sb_master_port #(
   parameter logic MASTER_ID      = 1'b1,
   parameter int   TIMEOUT_CYCLES = 64
) (
   input  logic        sb_clk,
   input  logic        sb_resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic [31:0] wr_data,
   output logic        wr_pop,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        done,
   output logic [1:0]  status,
   output logic        sb_busreq,
   input  logic        sb_grant,
   output logic [31:0] sb_addr,
   output logic        sb_write,
   output logic [1:0]  sb_trans,
   output logic [2:0]  sb_size,
   output logic [2:0]  sb_burst,
   output logic [31:0] sb_wdata,
   output logic        sb_master,
   output logic        sb_mastlock,
   input  logic        sb_ready,
   input  logic [1:0]  sb_resp,
   input  logic [31:0] sb_rdata,
   input  logic [1:0]  sb_split
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_SPLIT, S_DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] base_q;
   logic        write_q;
   logic [2:0]  size_q;
   logic [5:0]  total_q, cnt_q;
   logic        nseq_q;
   logic [TW-1:0] tcnt_q;
   logic [1:0]  status_q;
   logic [31:0] rd_data_q;
   logic        rd_valid_q;
   logic        act, rsp_err, rsp_split, beat_ok, tmo_hit, last, release_me;
   function automatic logic [5:0] beats(input logic [2:0] s);
      return s == 3'b011 ? 6'd2  :
             s == 3'b100 ? 6'd3  :
             s == 3'b101 ? 6'd8  :
             s == 3'b110 ? 6'd16 :
             s == 3'b111 ? 6'd32 : 6'd1;
   endfunction
   // Slave responses only count while this master owns the bus in S_XFER.
   assign act        = state_q == S_XFER && sb_grant;
   assign rsp_err    = act && sb_ready && sb_resp == 2'd2;
   assign rsp_split  = act && sb_ready && sb_resp == 2'd3;
   assign beat_ok    = act && sb_ready && sb_resp == 2'd1;
   assign tmo_hit    = act && !sb_ready && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
   assign last       = cnt_q + 6'd1 == total_q;
   assign release_me = MASTER_ID ? sb_split[0] : sb_split[1];
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cmd_valid) state_d = S_REQ;
         S_REQ:   if (sb_grant) state_d = S_XFER;
         S_XFER: begin
            if (rsp_err || tmo_hit || (beat_ok && last)) state_d = S_DONE;
            else if (rsp_split) state_d = S_SPLIT;
         end
         S_SPLIT: if (release_me) state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge sb_clk or negedge sb_resetn) begin
      if (!sb_resetn) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         write_q    <= 1'b0;
         size_q     <= '0;
         total_q    <= '0;
         cnt_q      <= '0;
         nseq_q     <= 1'b0;
         tcnt_q     <= '0;
         status_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= beat_ok && !write_q;
         if (beat_ok && !write_q) rd_data_q <= sb_rdata;
         if (state_q == S_IDLE && cmd_valid) begin
            base_q   <= cmd_addr;
            write_q  <= cmd_write;
            size_q   <= cmd_size;
            total_q  <= beats(cmd_size);
            cnt_q    <= '0;
            status_q <= '0;
         end else if (beat_ok) cnt_q <= cnt_q + 6'd1;
         if (rsp_err) status_q <= 2'd1;
         else if (tmo_hit) status_q <= 2'd2;
         // NONSEQ is re-armed on every (re)grant: entry from S_REQ or a lost grant mid-burst.
         if ((state_d == S_XFER && state_q != S_XFER) || (state_q == S_XFER && !sb_grant)) nseq_q <= 1'b1;
         else if (beat_ok) nseq_q <= 1'b0;
         if (state_q != S_XFER || sb_ready) tcnt_q <= '0;
         else if (sb_grant) tcnt_q <= tcnt_q + TW'(1);
      end
   end
   assign cmd_ready   = state_q == S_IDLE;
   assign sb_busreq   = state_q == S_REQ || state_q == S_XFER;
   assign sb_trans    = act ? (nseq_q ? 2'd2 : 2'd3) : 2'd0;
   assign sb_addr     = base_q + {26'd0, cnt_q};
   assign sb_write    = write_q;
   assign sb_size     = size_q;
   assign sb_burst    = 3'b001;
   assign sb_wdata    = wr_data;
   assign sb_master   = MASTER_ID;
   assign sb_mastlock = 1'b0;
   assign wr_pop      = beat_ok && write_q;
   assign done        = state_q == S_DONE;
   assign status      = status_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
endmodule

// File: tb/tb_sb_master_port.sv
// tb_sb_master_port: randomized slave/arbiter stimulus checked against a transaction-level model
module tb_sb_master_port;
   logic        sb_clk = 1'b0;
   logic        sb_resetn, cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, wr_data, rd_data, sb_addr, sb_wdata, sb_rdata;
   logic [2:0]  cmd_size, sb_size, sb_burst;
   logic        wr_pop, rd_valid, done, sb_busreq, sb_grant, sb_write, sb_master, sb_mastlock, sb_ready;
   logic [1:0]  status, sb_trans, sb_resp, sb_split;
   int checks = 0, errors = 0;
   int tbl [8] = '{1, 1, 1, 2, 3, 8, 16, 32};
   sb_master_port dut (
      .sb_clk(sb_clk), .sb_resetn(sb_resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size),
      .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .status(status),
      .sb_busreq(sb_busreq), .sb_grant(sb_grant), .sb_addr(sb_addr), .sb_write(sb_write),
      .sb_trans(sb_trans), .sb_size(sb_size), .sb_burst(sb_burst), .sb_wdata(sb_wdata),
      .sb_master(sb_master), .sb_mastlock(sb_mastlock),
      .sb_ready(sb_ready), .sb_resp(sb_resp), .sb_rdata(sb_rdata), .sb_split(sb_split)
   );
   always #5 sb_clk = ~sb_clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic check_idle_outputs(input string tag);
      check({tag, "_busreq"}, sb_busreq, 0);
      check({tag, "_trans"}, sb_trans, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_status"}, status, 0);
      check({tag, "_rd_data"}, rd_data, 0);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_wr_pop"}, wr_pop, 0);
      check({tag, "_addr"}, sb_addr, 0);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask
   // mode: 0 clean, 1 random waits/grant drops, 2 +random SPLIT, 3 +random ERROR,
   //       4 never ready, 5 SPLIT at beat 2, 6 ERROR at beat 1. rst_at>=0 resets at that beat.
   task automatic run_burst(input bit w, input logic [31:0] a, input logic [2:0] sz, input int mode, input int rst_at);
      int n = tbl[sz];
      int doneb = 0, phase = 0, tmo = 0, reqc = 0, cyc = 0, r = 0;
      bit fresh = 1'b1, pend = 1'b0, pend_n, split_used = 1'b0, fin = 1'b0, g, rdy, rel;
      logic [1:0] rsp, exp_st = 2'd0, exp_trans;
      logic [31:0] pv = '0;
      @(negedge sb_clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz;
      #1 check("cmd_ready_idle", cmd_ready, 1);
      @(posedge sb_clk);
      while (!fin && cyc < 3000) begin
         cyc++;
         @(negedge sb_clk);
         cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_size = 3'($urandom);
         wr_data = $urandom; sb_rdata = $urandom;
         g = 1'($urandom); rdy = 1'($urandom); rsp = 2'($urandom);
         rel = $urandom_range(0, 3) == 0;
         if (phase == 0) g = (mode >= 1 && mode <= 3) ? 1'($urandom) : reqc >= 2;
         if (phase == 1) begin
            case (mode)
               0: begin g = 1; rdy = 1; rsp = 1; end
               4: begin g = 1; rdy = 0; end
               5: begin g = 1; rdy = 1; rsp = (doneb == 2 && !split_used) ? 2'd3 : 2'd1; end
               6: begin g = 1; rdy = 1; rsp = (doneb == 1) ? 2'd2 : 2'd1; end
               default: begin
                  g = $urandom_range(0, 7) != 0;
                  rdy = $urandom_range(0, 3) != 0;
                  r = $urandom_range(0, 15);
                  rsp = r == 0 ? 2'd0 : (r == 1 && mode == 2) ? 2'd3 : (r == 2 && mode == 3) ? 2'd2 : 2'd1;
               end
            endcase
         end
         sb_grant = g; sb_ready = rdy; sb_resp = rsp;
         sb_split = {1'($urandom), (phase == 2) ? rel : 1'($urandom)};
         if (phase != 2) rel = 1'b0;
         if (rst_at >= 0 && phase == 1 && doneb == rst_at) begin
            sb_resetn = 1'b0;
            cmd_valid = 1'b0;
            #1 check_idle_outputs("reset_mid");
            @(negedge sb_clk);
            sb_resetn = 1'b1;
            return;
         end
         #1;
         exp_trans = (phase == 1 && g) ? (fresh ? 2'd2 : 2'd3) : 2'd0;
         check("busreq", sb_busreq, phase == 0 || phase == 1);
         check("cmd_ready_busy", cmd_ready, 0);
         check("done", done, phase == 3);
         if (phase == 3) check("status", status, exp_st);
         check("trans", sb_trans, exp_trans);
         if (exp_trans != 0) check("addr", sb_addr, a + doneb);
         check("wr_pop", wr_pop, phase == 1 && g && rdy && rsp == 1 && w);
         check("rd_valid", rd_valid, pend);
         if (pend) check("rd_data", rd_data, pv);
         check("wdata", sb_wdata, wr_data);
         check("write", sb_write, w);
         check("size", sb_size, sz);
         check("fixed", {sb_burst, sb_master, sb_mastlock}, 5'b00110);
         pend_n = 1'b0;
         case (phase)
            0: begin
               reqc++;
               if (g) begin phase = 1; fresh = 1; tmo = 0; end
            end
            1: begin
               if (!g) fresh = 1;
               else begin
                  if (rdy) tmo = 0;
                  if (rdy && rsp == 2) begin exp_st = 1; phase = 3; end
                  else if (rdy && rsp == 3) begin phase = 2; split_used = 1; end
                  else if (rdy && rsp == 1) begin
                     doneb++;
                     fresh = 0;
                     if (!w) begin pend_n = 1; pv = sb_rdata; end
                     if (doneb == n) phase = 3;
                  end else if (!rdy) begin
                     tmo++;
                     if (tmo == 64) begin exp_st = 2; phase = 3; end
                  end
               end
            end
            2: if (rel) begin phase = 0; reqc = 0; end
            default: fin = 1;
         endcase
         pend = pend_n;
      end
      cmd_valid = 1'b0;
      if (!fin) check("burst_bound", 0, 1);
   endtask
   initial begin
      sb_resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
      wr_data = '0; sb_grant = 1'b0; sb_ready = 1'b0; sb_resp = '0; sb_rdata = '0; sb_split = '0;
      repeat (3) @(posedge sb_clk);
      @(negedge sb_clk);
      check_idle_outputs("reset");
      sb_resetn = 1'b1;
      run_burst(1'b1, 32'h10,  3'b010, 0, -1);
      run_burst(1'b0, 32'h100, 3'b101, 0, -1);
      run_burst(1'b1, 32'h200, 3'b101, 5, -1);
      run_burst(1'b0, 32'h300, 3'b100, 6, -1);
      run_burst(1'b1, 32'h400, 3'b010, 4, -1);
      run_burst(1'b0, 32'h480, 3'b011, 4, -1);
      run_burst(1'b1, 32'h500, 3'b101, 0, 4);
      run_burst(1'b1, 32'h600, 3'b011, 0, -1);
      run_burst(1'b1, 32'hFFFF_FFFE, 3'b101, 0, -1);
      run_burst(1'b0, 32'h700, 3'b000, 0, -1);
      for (int i = 0; i < 40; i++)
         run_burst(1'($urandom), $urandom, 3'($urandom), $urandom_range(1, 3), -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
